// File: rtl/xup_range_searcher.sv
`default_nettype none
// ============================================================================
// Module   : xup_range_searcher
// Brief    : Successive-approximation search engine driving a range
//            comparator probe operand until it converges on the hidden target.
// Revision : 1.0 - initial release
// ============================================================================
module xup_range_searcher #(
  parameter int SIZE   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sign,
  output logic [SIZE-1:0] probe,
  output logic            sign_out,
  input  logic            cmp_gt,
  input  logic            cmp_eq,
  output logic [SIZE-1:0] result,
  output logic            busy,
  output logic            done,
  output logic            early
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int KW = (SIZE > 2) ? $clog2(SIZE) : 1;

  localparam logic [CW-1:0]   c_CNT_LAST = CW'(SETTLE - 1);
  localparam logic [KW-1:0]   c_K_TOP    = KW'(SIZE - 1);
  localparam logic [SIZE-1:0] c_MSB      = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SEARCH = 1'b1
  } state_t;

  state_t          r_state, w_state;
  logic [SIZE-1:0] r_code, w_code;
  logic [KW-1:0]   r_k, w_k;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_sign, w_sign;
  logic [SIZE-1:0] r_probe, w_probe;
  logic [SIZE-1:0] r_result, w_result;
  logic            r_done, w_done;
  logic            r_early, w_early;
  logic [SIZE-1:0] w_trial;
  logic [KW-1:0]   w_km1;

  // Offset-binary code to probe value: flipping the MSB for signed searches
  // makes the probe monotonic in the code for both interpretations.
  function automatic logic [SIZE-1:0] map_code(input logic [SIZE-1:0] code,
                                               input logic s);
    return code ^ (s ? c_MSB : {SIZE{1'b0}});
  endfunction

  // State and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_probe  <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_early  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_code   <= w_code;
      r_k      <= w_k;
      r_cnt    <= w_cnt;
      r_sign   <= w_sign;
      r_probe  <= w_probe;
      r_result <= w_result;
      r_done   <= w_done;
      r_early  <= w_early;
    end
  end

  // Next-state logic: launch on start, settle, then decide one bit per step.
  always_comb begin
    w_state  = r_state;
    w_code   = r_code;
    w_k      = r_k;
    w_cnt    = r_cnt;
    w_sign   = r_sign;
    w_probe  = r_probe;
    w_result = r_result;
    w_done   = 1'b0;
    w_early  = r_early;
    w_trial  = r_code;
    w_km1    = r_k - KW'(1);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sign  = sign;
          w_code  = c_MSB;
          w_k     = c_K_TOP;
          w_cnt   = '0;
          w_probe = map_code(c_MSB, sign);
          w_state = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (r_cnt != c_CNT_LAST) begin
          w_cnt = r_cnt + CW'(1);
        end else if (cmp_eq) begin
          // Exact hit: the probe on the comparator is the answer.
          w_result = r_probe;
          w_early  = 1'b1;
          w_done   = 1'b1;
          w_state  = S_IDLE;
        end else begin
          if (cmp_gt) begin
            w_trial[r_k] = 1'b0;
          end
          if (r_k == '0) begin
            w_code   = w_trial;
            w_result = map_code(w_trial, r_sign);
            w_early  = 1'b0;
            w_done   = 1'b1;
            w_state  = S_IDLE;
          end else begin
            w_trial[w_km1] = 1'b1;
            w_code  = w_trial;
            w_k     = w_km1;
            w_cnt   = '0;
            w_probe = map_code(w_trial, r_sign);
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign probe    = r_probe;
  assign sign_out = r_sign;
  assign result   = r_result;
  assign busy     = (r_state == S_SEARCH);
  assign done     = r_done;
  assign early    = r_early;

endmodule
`default_nettype wire

// File: tb/tb_xup_range_searcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_xup_range_searcher
// Brief    : Self-checking bench for xup_range_searcher with three SETTLE
//            variants and a behavioural comparator on each probe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xup_range_searcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       start    [3];
  logic       sign     [3];
  logic       sign_out [3];
  logic       gt       [3];
  logic       eq       [3];
  logic       busy     [3];
  logic       done     [3];
  logic       early    [3];
  logic [3:0] probe    [3];
  logic [3:0] result   [3];
  logic [3:0] target   [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xup_range_searcher #(.SIZE(4), .SETTLE(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start[0]), .sign(sign[0]),
    .probe(probe[0]), .sign_out(sign_out[0]), .cmp_gt(gt[0]), .cmp_eq(eq[0]),
    .result(result[0]), .busy(busy[0]), .done(done[0]), .early(early[0]));

  xup_range_searcher #(.SIZE(4), .SETTLE(2)) u_s2 (
    .clk(clk), .reset(reset), .start(start[1]), .sign(sign[1]),
    .probe(probe[1]), .sign_out(sign_out[1]), .cmp_gt(gt[1]), .cmp_eq(eq[1]),
    .result(result[1]), .busy(busy[1]), .done(done[1]), .early(early[1]));

  xup_range_searcher #(.SIZE(4), .SETTLE(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start[2]), .sign(sign[2]),
    .probe(probe[2]), .sign_out(sign_out[2]), .cmp_gt(gt[2]), .cmp_eq(eq[2]),
    .result(result[2]), .busy(busy[2]), .done(done[2]), .early(early[2]));

  // Behavioural range comparator: in1 = probe, in2 = target.
  function automatic logic cmp_gt_f(input logic [3:0] a, input logic [3:0] b,
                                    input logic s);
    return s ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  assign gt[0] = cmp_gt_f(probe[0], target[0], sign_out[0]);
  assign gt[1] = cmp_gt_f(probe[1], target[1], sign_out[1]);
  assign gt[2] = cmp_gt_f(probe[2], target[2], sign_out[2]);
  assign eq[0] = (probe[0] == target[0]);
  assign eq[1] = (probe[1] == target[1]);
  assign eq[2] = (probe[2] == target[2]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain binary search over the ordered value range.
  logic [3:0] m_probe [4];
  int         m_j;
  logic [3:0] m_res;
  logic       m_early;

  task automatic model(input logic sgn, input logic [3:0] tgt);
    int off, tval, tcode, lo, trial;
    off   = sgn ? 8 : 0;
    tval  = (sgn && tgt >= 8) ? int'(tgt) - 16 : int'(tgt);
    tcode = tval + off;          // position of target in the 0..15 ordering
    lo    = 0;
    m_j   = 4;
    m_early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      trial = lo + (8 >> i);
      m_probe[i] = 4'(trial - off);
      if (!m_early) begin
        if (trial == tcode) begin
          m_early = 1'b1;
          m_j     = i + 1;
        end else if (trial < tcode) begin
          lo = trial;
        end
      end
    end
    m_res = m_early ? tgt : 4'(lo - off);
  endtask

  // Runs one search on instance d; caller is positioned at a falling edge.
  task automatic search(input int d, input logic sgn, input logic [3:0] tgt,
                        input bit noise, input bit use_exp,
                        input logic [3:0] er, input logic ee, input int ec);
    int S, cyc, idx;
    logic [3:0] eres;
    logic       eearly;
    S = d + 1;
    model(sgn, tgt);
    cyc    = use_exp ? ec : m_j * S;
    eres   = use_exp ? er : m_res;
    eearly = use_exp ? ee : m_early;
    start[d]  = 1'b1;
    sign[d]   = sgn;
    target[d] = tgt;
    @(negedge clk);
    start[d] = 1'b0;
    for (int m = 0; m <= cyc; m++) begin
      idx = (m / S > 3) ? 3 : m / S;
      if (m < cyc) begin
        chk($sformatf("busy[%0d] t=%0d m=%0d", d, tgt, m), busy[d], 1);
        chk($sformatf("done[%0d] t=%0d m=%0d", d, tgt, m), done[d], 0);
        chk($sformatf("probe[%0d] t=%0d m=%0d", d, tgt, m), probe[d], m_probe[idx]);
        chk($sformatf("sign_out[%0d] t=%0d", d, tgt), sign_out[d], sgn);
        if (noise) begin
          start[d] = m[0];
          sign[d]  = ~sgn;
        end
        @(negedge clk);
      end else begin
        idx = (m_j > 4) ? 3 : m_j - 1;
        chk($sformatf("done_pulse[%0d] t=%0d", d, tgt), done[d], 1);
        chk($sformatf("busy_end[%0d] t=%0d", d, tgt), busy[d], 0);
        chk($sformatf("result[%0d] s=%0d t=%0d", d, sgn, tgt), result[d], eres);
        chk($sformatf("early[%0d] s=%0d t=%0d", d, sgn, tgt), early[d], eearly);
        chk($sformatf("probe_hold[%0d] t=%0d", d, tgt), probe[d], m_probe[idx]);
      end
    end
    start[d] = 1'b0;
    sign[d]  = sgn;
  endtask

  typedef struct {
    int         d;
    logic       sgn;
    logic [3:0] tgt;
    logic [3:0] res;
    logic       ee;
    int         cyc;
  } vec_t;

  vec_t tbl [8];
  bit   saw_done;

  initial begin
    tbl[0] = '{0, 1'b0, 4'd11, 4'd11, 1'b1, 4};
    tbl[1] = '{0, 1'b0, 4'd8,  4'd8,  1'b1, 1};
    tbl[2] = '{0, 1'b0, 4'd0,  4'd0,  1'b0, 4};
    tbl[3] = '{0, 1'b1, 4'hD,  4'hD,  1'b1, 4};
    tbl[4] = '{0, 1'b1, 4'h8,  4'h8,  1'b0, 4};
    tbl[5] = '{2, 1'b0, 4'd5,  4'd5,  1'b1, 12};
    tbl[6] = '{1, 1'b0, 4'd15, 4'd15, 1'b1, 8};
    tbl[7] = '{0, 1'b1, 4'd7,  4'd7,  1'b1, 4};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; sign[i] = 1'b0; target[i] = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_probe[%0d]", i), probe[i], 0);
      chk($sformatf("rst_result[%0d]", i), result[i], 0);
      chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
      chk($sformatf("rst_done[%0d]", i), done[i], 0);
      chk($sformatf("rst_early[%0d]", i), early[i], 0);
      chk($sformatf("rst_sign[%0d]", i), sign_out[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors; consecutive entries on one instance run back-to-back.
    for (int i = 0; i < 8; i++)
      search(tbl[i].d, tbl[i].sgn, tbl[i].tgt, 1'b0, 1'b1,
             tbl[i].res, tbl[i].ee, tbl[i].cyc);
    @(negedge clk);

    // Start pulses and sign toggles while busy must be ignored.
    search(1, 1'b0, 4'd11, 1'b1, 1'b0, 4'd0, 1'b0, 0);
    search(2, 1'b1, 4'd3,  1'b1, 1'b0, 4'd0, 1'b0, 0);
    @(negedge clk);

    // Reset mid-search: abort, clear outputs, no done afterwards.
    start[2] = 1'b1; sign[2] = 1'b1; target[2] = 4'd5;
    @(negedge clk);
    start[2] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy[2], 0);
    chk("abort_probe", probe[2], 0);
    chk("abort_sign", sign_out[2], 0);
    saw_done = 1'b0;
    for (int m = 0; m < 15; m++) begin
      if (done[2] || busy[2]) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", saw_done, 0);
    search(2, 1'b0, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 0);
    @(negedge clk);

    // Exhaustive sweep for SETTLE=1 and SETTLE=2, both signs.
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++)
        for (int t = 0; t < 16; t++)
          search(d, s[0], t[3:0], 1'b0, 1'b0, 4'd0, 1'b0, 0);
    @(negedge clk);

    // Random mix across all instances with optional busy-time noise.
    for (int r = 0; r < 40; r++) begin
      search(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'b0, 4'd0, 1'b0, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
